// File: rtl/jacobian_to_affine_if.sv
// Start/operand/result bundle between the Jacobian-to-affine converter and its requester.
interface jacobian_to_affine_if;
  logic         i_start;
  logic [255:0] X;
  logic [255:0] Y;
  logic [255:0] Z;
  logic [255:0] p;
  logic [255:0] x_aff;
  logic [255:0] y_aff;
  logic         o_inf;
  logic         o_busy;
  logic         o_done;

  modport master (
    output i_start, X, Y, Z, p,
    input  x_aff, y_aff, o_inf, o_busy, o_done
  );

  modport slave (
    input  i_start, X, Y, Z, p,
    output x_aff, y_aff, o_inf, o_busy, o_done
  );
endinterface

// File: rtl/jacobian_to_affine.sv
// Converts a Jacobian point (X,Y,Z) to affine (X/Z^2, Y/Z^3) mod p using a binary
// extended-Euclid inverse followed by four passes of a bit-serial modular multiplier.
module jacobian_to_affine (
  input  logic                 i_clk,
  input  logic                 i_rst,
  jacobian_to_affine_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_INV, S_MUL_ZZ, S_MUL_ZZZ, S_MUL_X, S_MUL_Y, S_DONE
  } state_t;

  state_t       r_state, w_next;
  logic [255:0] r_x, r_y, r_z, r_p;
  logic [255:0] r_u, r_v, r_a, r_b;
  logic [255:0] r_zi, r_zi2, r_zi3;
  logic [255:0] r_x_aff, r_y_aff;
  logic [257:0] r_acc;
  logic [7:0]   r_idx;
  logic         r_inf, r_busy, r_done;

  logic [255:0] w_mul_a, w_mul_b;
  logic [257:0] w_p_ext, w_dbl, w_dbl_red, w_sum, w_sum_red, w_acc_next;
  logic         w_u_one, w_v_one, w_mul_last;

  // Halving mod p: odd values get p added first so the shift stays exact.
  function automatic logic [255:0] half_mod(input logic [255:0] a, input logic [255:0] m);
    logic [256:0] s;
    if (a[0]) begin
      s = {1'b0, a} + {1'b0, m};
    end else begin
      s = {1'b0, a};
    end
    return 256'(s >> 1);
  endfunction

  function automatic logic [255:0] sub_mod(input logic [255:0] a, input logic [255:0] b,
                                           input logic [255:0] m);
    logic [256:0] d;
    if (a >= b) begin
      d = {1'b0, a} - {1'b0, b};
    end else begin
      d = {1'b0, a} + {1'b0, m} - {1'b0, b};
    end
    return 256'(d);
  endfunction

  assign w_u_one    = (r_u == 256'd1);
  assign w_v_one    = (r_v == 256'd1);
  assign w_mul_last = (r_idx == 8'd0);

  // Shared multiplier operand selection for the four product passes.
  always_comb begin
    w_mul_a = 256'd0;
    w_mul_b = 256'd0;
    case (r_state)
      S_MUL_ZZ:  begin w_mul_a = r_zi;  w_mul_b = r_zi;  end
      S_MUL_ZZZ: begin w_mul_a = r_zi2; w_mul_b = r_zi;  end
      S_MUL_X:   begin w_mul_a = r_x;   w_mul_b = r_zi2; end
      S_MUL_Y:   begin w_mul_a = r_y;   w_mul_b = r_zi3; end
      default:   begin w_mul_a = 256'd0; w_mul_b = 256'd0; end
    endcase
  end

  // One MSB-first interleaved step: acc = 2*acc mod p, then conditionally + A mod p.
  always_comb begin
    w_p_ext = {2'b00, r_p};
    w_dbl   = r_acc << 1;
    if (w_dbl >= w_p_ext) begin
      w_dbl_red = w_dbl - w_p_ext;
    end else begin
      w_dbl_red = w_dbl;
    end
    w_sum = w_dbl_red + {2'b00, w_mul_a};
    if (w_sum >= w_p_ext) begin
      w_sum_red = w_sum - w_p_ext;
    end else begin
      w_sum_red = w_sum;
    end
    if (w_mul_b[r_idx]) begin
      w_acc_next = w_sum_red;
    end else begin
      w_acc_next = w_dbl_red;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.i_start) w_next = S_CHECK; else w_next = S_IDLE;
      S_CHECK:   if (r_z == 256'd0) w_next = S_DONE; else w_next = S_INV;
      S_INV:     if (w_u_one || w_v_one) w_next = S_MUL_ZZ; else w_next = S_INV;
      S_MUL_ZZ:  if (w_mul_last) w_next = S_MUL_ZZZ; else w_next = S_MUL_ZZ;
      S_MUL_ZZZ: if (w_mul_last) w_next = S_MUL_X; else w_next = S_MUL_ZZZ;
      S_MUL_X:   if (w_mul_last) w_next = S_MUL_Y; else w_next = S_MUL_X;
      S_MUL_Y:   if (w_mul_last) w_next = S_DONE; else w_next = S_MUL_Y;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // State register plus busy/done flags aligned with the state they describe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
    end
  end

  // Operand capture, inversion steps, multiplier accumulator and result registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x <= 256'd0; r_y <= 256'd0; r_z <= 256'd0; r_p <= 256'd0;
      r_u <= 256'd0; r_v <= 256'd0; r_a <= 256'd0; r_b <= 256'd0;
      r_zi <= 256'd0; r_zi2 <= 256'd0; r_zi3 <= 256'd0;
      r_x_aff <= 256'd0; r_y_aff <= 256'd0; r_inf <= 1'b0;
      r_acc <= 258'd0; r_idx <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_x <= bus.X; r_y <= bus.Y; r_z <= bus.Z; r_p <= bus.p;
          end
        end
        S_CHECK: begin
          if (r_z == 256'd0) begin
            r_x_aff <= 256'd0;
            r_y_aff <= 256'd0;
            r_inf   <= 1'b1;
          end else begin
            r_inf <= 1'b0;
          end
          r_u <= r_z; r_v <= r_p; r_a <= 256'd1; r_b <= 256'd0;
          r_acc <= 258'd0;
          r_idx <= 8'd255;
        end
        S_INV: begin
          if (w_u_one) begin
            r_zi <= r_a;
          end else if (w_v_one) begin
            r_zi <= r_b;
          end else if (!r_u[0]) begin
            r_u <= r_u >> 1;
            r_a <= half_mod(r_a, r_p);
          end else if (!r_v[0]) begin
            r_v <= r_v >> 1;
            r_b <= half_mod(r_b, r_p);
          end else if (r_u >= r_v) begin
            r_u <= r_u - r_v;
            r_a <= sub_mod(r_a, r_b, r_p);
          end else begin
            r_v <= r_v - r_u;
            r_b <= sub_mod(r_b, r_a, r_p);
          end
        end
        S_MUL_ZZ, S_MUL_ZZZ, S_MUL_X, S_MUL_Y: begin
          r_idx <= r_idx - 8'd1;
          if (w_mul_last) begin
            r_acc <= 258'd0;
            case (r_state)
              S_MUL_ZZ:  r_zi2   <= w_acc_next[255:0];
              S_MUL_ZZZ: r_zi3   <= w_acc_next[255:0];
              S_MUL_X:   r_x_aff <= w_acc_next[255:0];
              S_MUL_Y:   r_y_aff <= w_acc_next[255:0];
              default:   r_zi2   <= r_zi2;
            endcase
          end else begin
            r_acc <= w_acc_next;
          end
        end
        default: begin
          r_idx <= r_idx;
        end
      endcase
    end
  end

  assign bus.x_aff  = r_x_aff;
  assign bus.y_aff  = r_y_aff;
  assign bus.o_inf  = r_inf;
  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;

endmodule

// File: tb/tb_jacobian_to_affine.sv
// Directed and random checks of jacobian_to_affine against a Fermat-inverse golden model.
module tb_jacobian_to_affine;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  jacobian_to_affine_if bus ();
  jacobian_to_affine dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  localparam logic [255:0] P23  = 256'd23;
  localparam logic [255:0] P256 =
    256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

  typedef struct {
    logic [255:0] x;
    logic [255:0] y;
    logic         inf;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b,
                                          input logic [255:0] m);
    logic [511:0] t;
    t = {256'd0, a} * {256'd0, b};
    t = t % {256'd0, m};
    return t[255:0];
  endfunction

  function automatic logic [255:0] powmod(input logic [255:0] b, input logic [255:0] e,
                                          input logic [255:0] m);
    logic [255:0] r;
    r = 256'd1;
    for (int i = 255; i >= 0; i--) begin
      r = mulmod(r, r, m);
      if (e[i]) r = mulmod(r, b, m);
    end
    return r;
  endfunction

  function automatic logic [255:0] rand256(input logic [255:0] m);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r % m;
  endfunction

  // Push the golden result, run one conversion, then pop and compare on o_done.
  task automatic do_op(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z,
                       input logic [255:0] pp, input int lat_lo, input int lat_hi,
                       input int repulse_at);
    exp_t         e;
    exp_t         got;
    int           lat;
    logic [255:0] zi, zi2, zi3;
    if (z == 256'd0) begin
      e.x = 256'd0; e.y = 256'd0; e.inf = 1'b1;
    end else begin
      zi  = powmod(z, pp - 256'd2, pp);
      zi2 = mulmod(zi, zi, pp);
      zi3 = mulmod(zi2, zi, pp);
      e.x = mulmod(x, zi2, pp);
      e.y = mulmod(y, zi3, pp);
      e.inf = 1'b0;
    end
    q.push_back(e);
    bus.X = x; bus.Y = y; bus.Z = z; bus.p = pp;
    bus.i_start = 1'b1;
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;
    lat = 1;
    while (bus.o_done !== 1'b1 && lat < 3000) begin
      if (lat == repulse_at) begin
        check("busy_at_repulse", bus.o_busy, 1'b1);
        bus.i_start = 1'b1;
        bus.Z = 256'd1;
      end else begin
        bus.i_start = 1'b0;
      end
      @(posedge i_clk); #1;
      lat++;
    end
    bus.i_start = 1'b0;
    check("done_seen", bus.o_done, 1'b1);
    check("latency_min", (lat >= lat_lo), 1'b1);
    check("latency_max", (lat <= lat_hi), 1'b1);
    if (q.size() == 0) begin
      check("scoreboard_nonempty", 1'b0, 1'b1);
    end else begin
      got = q.pop_front();
      check("x_aff", bus.x_aff, got.x);
      check("y_aff", bus.y_aff, got.y);
      check("o_inf", bus.o_inf, got.inf);
    end
    @(posedge i_clk); #1;
    check("done_one_cycle", bus.o_done, 1'b0);
    check("idle_after_done", bus.o_busy, 1'b0);
  endtask

  initial begin
    int done_cnt;
    logic [255:0] rx, ry, rz;
    i_rst = 1'b1;
    bus.i_start = 1'b0;
    bus.X = 256'd0; bus.Y = 256'd0; bus.Z = 256'd0; bus.p = 256'd0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_x_aff", bus.x_aff, 256'd0);
    check("rst_y_aff", bus.y_aff, 256'd0);
    check("rst_inf", bus.o_inf, 1'b0);
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_done", bus.o_done, 1'b0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Z=1: one inversion step, so latency 1+1+1024+1 edges.
    do_op(256'd5, 256'd7, 256'd1, P23, 1027, 1027, -1);
    // Z=2: two inversion steps (halve, then u==1).
    do_op(256'd5, 256'd7, 256'd2, P23, 1028, 1028, -1);
    // Point at infinity: CHECK then DONE.
    do_op(256'd5, 256'd7, 256'd0, P23, 2, 2, -1);
    // Start re-pulsed with Z=1 mid-operation must be ignored.
    do_op(256'd5, 256'd7, 256'd2, P23, 1028, 1028, 10);
    done_cnt = 0;
    repeat (40) begin
      @(posedge i_clk); #1;
      if (bus.o_done === 1'b1) done_cnt++;
    end
    check("no_extra_done", done_cnt, 0);

    // Abort during MUL_X (entered about 516 edges after start for Z=2).
    bus.X = 256'd5; bus.Y = 256'd7; bus.Z = 256'd2; bus.p = P23;
    bus.i_start = 1'b1;
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;
    done_cnt = 0;
    repeat (650) begin
      @(posedge i_clk); #1;
      if (bus.o_done === 1'b1) done_cnt++;
    end
    check("busy_before_abort", bus.o_busy, 1'b1);
    i_rst = 1'b1;
    #1;
    check("abort_x_aff", bus.x_aff, 256'd0);
    check("abort_y_aff", bus.y_aff, 256'd0);
    check("abort_busy", bus.o_busy, 1'b0);
    check("abort_done", bus.o_done, 1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    repeat (1100) begin
      @(posedge i_clk); #1;
      if (bus.o_done === 1'b1) done_cnt++;
    end
    check("no_done_after_abort", done_cnt, 0);
    do_op(256'd5, 256'd7, 256'd2, P23, 1028, 1028, -1);

    // Random P-256 points; inversion may take 1..1024 steps.
    for (int k = 0; k < 20; k++) begin
      rx = rand256(P256);
      ry = rand256(P256);
      rz = rand256(P256);
      if (rz == 256'd0) rz = 256'd1;
      do_op(rx, ry, rz, P256, 1027, 2050, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
